// File: rtl/reg_file_16_pkg.sv
// reg_file_16 shared constants.
// Also used by issue logic and the writeback mux.
package reg_file_16_pkg;
  localparam int REG_W    = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/mux_16.sv
// MUX_16: two-input word select.
// S=0 passes D1, S=1 passes D2.
module mux_16
  import reg_file_16_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic         i_s,
  output logic [W-1:0] o_y
);
  assign o_y = i_s ? i_d2 : i_d1;
endmodule

// File: rtl/reg_file_16_reg16.sv
// reg16: word register with sync clear and load.
// Clear takes priority over load.
module reg16
  import reg_file_16_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/reg_file_16.sv
// reg_file_16: 8x16 register file, R0 = 0,
// write-through bypass and pending-write scoreboard.
module reg_file_16
  import reg_file_16_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              ISS_EN,
  input  logic [ADDR_W-1:0] ISS_A,
  output logic              BUSY1,
  output logic              BUSY2
);
  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR =
    ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] w_q [N];
  logic [N-1:1]      w_ld;
  logic [N-1:1]      r_pend;
  logic [N-1:0]      w_pend;
  logic              w_hit1, w_hit2;
  logic [DATA_W-1:0] w_m1, w_m2;

  assign w_q[0] = '0;

  for (genvar g = 1; g < N; g++) begin : g_reg
    assign w_ld[g] = WE && (WA == ADDR_W'(g));
    reg16 #(.W(DATA_W)) u_reg (
      .i_clk (CLK),
      .i_clr (RST),
      .i_ld  (w_ld[g]),
      .i_d   (WD),
      .o_q   (w_q[g])
    );
  end

  // Issue beats writeback: a newer writer is outstanding.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (ISS_EN && ISS_A == ADDR_W'(i))
          r_pend[i] <= 1'b1;
        else if (w_ld[i])
          r_pend[i] <= 1'b0;
      end
    end
  end

  assign w_pend = {r_pend, 1'b0};

  assign w_hit1 = WE && WA == RA1 && RA1 != ZR;
  assign w_hit2 = WE && WA == RA2 && RA2 != ZR;

  mux_16 #(.W(DATA_W)) u_mux1 (
    .i_d1 (w_q[RA1]),
    .i_d2 (WD),
    .i_s  (w_hit1),
    .o_y  (w_m1)
  );

  mux_16 #(.W(DATA_W)) u_mux2 (
    .i_d1 (w_q[RA2]),
    .i_d2 (WD),
    .i_s  (w_hit2),
    .o_y  (w_m2)
  );

  assign RD1   = RST ? '0 : w_m1;
  assign RD2   = RST ? '0 : w_m2;
  assign BUSY1 = !RST && w_pend[RA1] && !w_hit1;
  assign BUSY2 = !RST && w_pend[RA2] && !w_hit2;
endmodule

// File: tb/tb_reg_file_16.sv
// tb_reg_file_16: directed and random checks
// against a behavioural register-file model.
module tb_reg_file_16;
  logic        CLK = 1'b0;
  logic        RST, WE, ISS_EN;
  logic [2:0]  WA, RA1, RA2, ISS_A;
  logic [15:0] WD, RD1, RD2;
  logic        BUSY1, BUSY2;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_reg [8];
  logic        m_pend [8];

  always #5 CLK = ~CLK;

  reg_file_16 dut (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (WE),
    .WA     (WA),
    .WD     (WD),
    .RA1    (RA1),
    .RA2    (RA2),
    .RD1    (RD1),
    .RD2    (RD2),
    .ISS_EN (ISS_EN),
    .ISS_A  (ISS_A),
    .BUSY1  (BUSY1),
    .BUSY2  (BUSY2)
  );

  function automatic logic [15:0] exp_rd(
    input logic [2:0] ra);
    if (RST) return 16'h0;
    if (ra == 3'd0) return 16'h0;
    if (WE && WA == ra) return WD;
    return m_reg[ra];
  endfunction

  function automatic logic exp_busy(
    input logic [2:0] ra);
    if (RST || ra == 3'd0) return 1'b0;
    return m_pend[ra] && !(WE && WA == ra);
  endfunction

  task automatic step();
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 16'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (WE && WA != 3'd0) begin
        m_reg[WA]  = WD;
        m_pend[WA] = 1'b0;
      end
      if (ISS_EN && ISS_A != 3'd0)
        m_pend[ISS_A] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1; WE = 1; WA = 3; WD = 16'h5555;
    ISS_EN = 1; ISS_A = 3; RA1 = 3; RA2 = 7;
    #1;
    n_vec++;
    if (RD1 !== 16'h0 || BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_hold rd1=%h b1=%b want 0000/0",
               RD1, BUSY1);
    end
    step();
    RST = 0; WE = 0; ISS_EN = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'h0 || RD2 !== 16'h0) begin
      n_err++;
      $display("FAIL rst_rd rd1=%h rd2=%h want 0000",
               RD1, RD2);
    end
    n_vec++;
    if (BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy b1=%b b2=%b want 0",
               BUSY1, BUSY2);
    end
  endtask

  task automatic test_r0();
    WE = 1; WA = 0; WD = 16'hFFFF; RA1 = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'h0) begin
      n_err++;
      $display("FAIL r0_during rd1=%h want 0000", RD1);
    end
    step();
    WE = 0; ISS_EN = 1; ISS_A = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'h0) begin
      n_err++;
      $display("FAIL r0_after rd1=%h want 0000", RD1);
    end
    step();
    ISS_EN = 0;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL r0_busy b1=%b want 0", BUSY1);
    end
  endtask

  task automatic test_write_bypass();
    WE = 1; WA = 5; WD = 16'hA5C3; RA1 = 5; RA2 = 4;
    #1;
    n_vec++;
    if (RD1 !== 16'hA5C3) begin
      n_err++;
      $display("FAIL bypass rd1=%h want a5c3", RD1);
    end
    step();
    WE = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'hA5C3) begin
      n_err++;
      $display("FAIL stored rd1=%h want a5c3", RD1);
    end
    n_vec++;
    if (RD2 !== 16'h0) begin
      n_err++;
      $display("FAIL other_reg rd2=%h want 0000", RD2);
    end
  endtask

  task automatic test_scoreboard();
    ISS_EN = 1; ISS_A = 2; RA1 = 2;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL iss_nobypass b1=%b want 0", BUSY1);
    end
    step();
    ISS_EN = 0;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b1) begin
      n_err++;
      $display("FAIL iss_set b1=%b want 1", BUSY1);
    end
    WE = 1; WA = 2; WD = 16'h1234;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b0 || RD1 !== 16'h1234) begin
      n_err++;
      $display("FAIL wb_resolve b1=%b rd1=%h want 0/1234",
               BUSY1, RD1);
    end
    step();
    WE = 0;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL pend_clr b1=%b want 0", BUSY1);
    end
  endtask

  task automatic test_simul();
    ISS_EN = 1; ISS_A = 6;
    step();
    ISS_EN = 0; RA1 = 6;
    #1;
    n_vec++;
    if (BUSY1 !== 1'b1) begin
      n_err++;
      $display("FAIL sim_pre b1=%b want 1", BUSY1);
    end
    WE = 1; WA = 6; WD = 16'h0F0F;
    ISS_EN = 1; ISS_A = 6;
    step();
    WE = 0; ISS_EN = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'h0F0F || BUSY1 !== 1'b1) begin
      n_err++;
      $display("FAIL sim_post rd1=%h b1=%b want 0f0f/1",
               RD1, BUSY1);
    end
  endtask

  task automatic test_reset_mid();
    WE = 1; WA = 1; WD = 16'hBEEF;
    ISS_EN = 1; ISS_A = 1;
    step();
    WE = 0; ISS_EN = 0; RA1 = 1; RA2 = 5;
    #1;
    n_vec++;
    if (RD1 !== 16'hBEEF || BUSY1 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre rd1=%h b1=%b want beef/1",
               RD1, BUSY1);
    end
    RST = 1; WE = 1; WA = 1; WD = 16'h1111;
    #1;
    n_vec++;
    if (RD1 !== 16'h0 || BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_hold rd1=%h b1=%b want 0000/0",
               RD1, BUSY1);
    end
    step();
    RST = 0; WE = 0;
    #1;
    n_vec++;
    if (RD1 !== 16'h0 || BUSY1 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_post rd1=%h b1=%b want 0000/0",
               RD1, BUSY1);
    end
    n_vec++;
    if (RD2 !== 16'h0) begin
      n_err++;
      $display("FAIL mid_clr5 rd2=%h want 0000", RD2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RST    = ($urandom_range(39) == 0);
      WE     = $urandom_range(1);
      WA     = 3'($urandom_range(7));
      WD     = 16'($urandom);
      ISS_EN = ($urandom_range(2) == 0);
      ISS_A  = 3'($urandom_range(7));
      RA1    = 3'($urandom_range(7));
      RA2    = ($urandom_range(7) == 0) ? RA1
               : 3'($urandom_range(7));
      #1;
      n_vec++;
      if (RD1 !== exp_rd(RA1) || RD2 !== exp_rd(RA2)) begin
        n_err++;
        $display("FAIL rnd_rd c=%0d rd1=%h/%h rd2=%h/%h",
                 c, RD1, exp_rd(RA1), RD2, exp_rd(RA2));
      end
      n_vec++;
      if (BUSY1 !== exp_busy(RA1) ||
          BUSY2 !== exp_busy(RA2)) begin
        n_err++;
        $display("FAIL rnd_busy c=%0d b1=%b/%b b2=%b/%b",
                 c, BUSY1, exp_busy(RA1),
                 BUSY2, exp_busy(RA2));
      end
      step();
    end
    RST = 0; WE = 0; ISS_EN = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = 16'h0;
      m_pend[i] = 1'b0;
    end
    RST = 1; WE = 0; WA = 0; WD = 0;
    ISS_EN = 0; ISS_A = 0; RA1 = 0; RA2 = 0;
    #2;
    test_reset();
    test_r0();
    test_write_bypass();
    test_scoreboard();
    test_simul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
